// File: rtl/imem_arbiter_if.sv
// Request/response and memory-side signals of the instruction-memory arbiter.
// The arbiter uses the slave modport; the fetch stage, debug unit and memory use master.
interface imem_arbiter_if #(
  parameter int unsigned IDX_W = 14
);
  logic             dbg_halt;

  logic             fetch_req_valid;
  logic             fetch_req_ready;
  logic [31:0]      fetch_addr;
  logic             fetch_flush;
  logic             fetch_rsp_valid;
  logic [31:0]      fetch_rsp_data;
  logic             fetch_rsp_err;

  logic             dbg_req_valid;
  logic             dbg_req_ready;
  logic             dbg_we;
  logic [31:0]      dbg_addr;
  logic [31:0]      dbg_wdata;
  logic             dbg_rsp_valid;
  logic [31:0]      dbg_rsp_rdata;
  logic             dbg_rsp_err;

  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_index;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  dbg_halt, fetch_req_valid, fetch_addr, fetch_flush,
    input  dbg_req_valid, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err,
    output mem_en, mem_we, mem_index, mem_wdata
  );

  modport master (
    output dbg_halt, fetch_req_valid, fetch_addr, fetch_flush,
    output dbg_req_valid, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err,
    input  mem_en, mem_we, mem_index, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares a single-ported instruction memory between fetch and debug: round-robin arbitration,
// byte-address to word-index translation with range checks, and one-cycle response path.
module imem_arbiter #(
  parameter int unsigned DEPTH = 10240,
  parameter logic [31:0] BASE  = 32'h4,
  parameter int unsigned IDX_W = 14
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OwnNone, OwnFetch, OwnDbg} owner_e;

  owner_e rsp_owner_q, rsp_owner_d;
  logic   rsp_err_q, rsp_err_d;
  logic   rsp_is_write_q, rsp_is_write_d;
  logic   fetch_kill_q, fetch_kill_d;
  logic   last_dbg_q, last_dbg_d;

  logic fetch_err, dbg_err;
  logic grant_fetch, grant_dbg;

  function automatic logic addr_err(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (addr[1:0] != 2'b00) || (addr < BASE) || ((off >> 2) >= DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return IDX_W'(off >> 2);
  endfunction

  // Halt hands debug the port outright; otherwise a tie goes to whoever lost last time.
  always_comb begin
    fetch_err   = addr_err(bus.fetch_addr);
    dbg_err     = addr_err(bus.dbg_addr);
    grant_dbg   = !rst && bus.dbg_req_valid &&
                  (bus.dbg_halt || !bus.fetch_req_valid || !last_dbg_q);
    grant_fetch = !rst && bus.fetch_req_valid && !bus.dbg_halt && !grant_dbg;
  end

  always_comb begin
    bus.fetch_req_ready = grant_fetch;
    bus.dbg_req_ready   = grant_dbg;
    bus.mem_en          = (grant_dbg && !dbg_err) || (grant_fetch && !fetch_err);
    bus.mem_we          = grant_dbg && !dbg_err && bus.dbg_we;
    bus.mem_index       = '0;
    if (bus.mem_en) begin
      bus.mem_index = grant_dbg ? word_idx(bus.dbg_addr) : word_idx(bus.fetch_addr);
    end
    bus.mem_wdata       = bus.mem_we ? bus.dbg_wdata : 32'h0;
  end

  always_comb begin
    rsp_owner_d    = OwnNone;
    rsp_err_d      = 1'b0;
    rsp_is_write_d = 1'b0;
    fetch_kill_d   = 1'b0;
    last_dbg_d     = last_dbg_q;
    if (grant_dbg) begin
      rsp_owner_d    = OwnDbg;
      rsp_err_d      = dbg_err;
      rsp_is_write_d = bus.dbg_we;
      last_dbg_d     = 1'b1;
    end else if (grant_fetch) begin
      rsp_owner_d    = OwnFetch;
      rsp_err_d      = fetch_err;
      fetch_kill_d   = bus.fetch_flush;
      last_dbg_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner_q    <= OwnNone;
      rsp_err_q      <= 1'b0;
      rsp_is_write_q <= 1'b0;
      fetch_kill_q   <= 1'b0;
      last_dbg_q     <= 1'b0;
    end else begin
      rsp_owner_q    <= rsp_owner_d;
      rsp_err_q      <= rsp_err_d;
      rsp_is_write_q <= rsp_is_write_d;
      fetch_kill_q   <= fetch_kill_d;
      last_dbg_q     <= last_dbg_d;
    end
  end

  // A flush in either the accept cycle or the response cycle kills the fetch response.
  always_comb begin
    bus.fetch_rsp_valid = (rsp_owner_q == OwnFetch) && !fetch_kill_q && !bus.fetch_flush;
    bus.fetch_rsp_err   = bus.fetch_rsp_valid && rsp_err_q;
    bus.fetch_rsp_data  = (bus.fetch_rsp_valid && !rsp_err_q) ? bus.mem_rdata : 32'h0;
    bus.dbg_rsp_valid   = (rsp_owner_q == OwnDbg);
    bus.dbg_rsp_err     = bus.dbg_rsp_valid && rsp_err_q;
    bus.dbg_rsp_rdata   = (bus.dbg_rsp_valid && !rsp_err_q && !rsp_is_write_q) ?
                          bus.mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model with its own shadow memory.
module tb_imem_arbiter;
  localparam int unsigned DEPTH = 10240;
  localparam logic [31:0] BASE  = 32'h4;
  localparam int unsigned IDX_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_arbiter_if #(.IDX_W(IDX_W)) bus ();

  imem_arbiter #(.DEPTH(DEPTH), .BASE(BASE), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] minit(input int unsigned i);
    return (i * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  // Memory device: synchronous one-cycle read, write on mem_we.
  logic [31:0] dev_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en && (32'(bus.mem_index) < DEPTH)) begin
      if (bus.mem_we) dev_mem[bus.mem_index] <= bus.mem_wdata;
      else            bus.mem_rdata <= dev_mem[bus.mem_index];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_fetch;
    bit          err;
    bit          kill;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] model_mem [DEPTH];
  rsp_t        exp_q [$];
  bit          m_last_dbg = 1'b0;
  bit          f_hold = 1'b0;
  bit          d_hold = 1'b0;

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= DEPTH);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  always @(negedge clk) begin : model
    rsp_t        r;
    bit          gd, gf, ferr, derr, exp_en, exp_we;
    bit          exp_fv, exp_fe, exp_dv, exp_de;
    logic [31:0] exp_fd, exp_dd;
    int unsigned idx;
    if (rst) begin
      exp_q.delete();
      m_last_dbg = 1'b0;
      f_hold = 1'b0;
      d_hold = 1'b0;
      chk("rst_fetch_ready", 32'(bus.fetch_req_ready), 0);
      chk("rst_dbg_ready", 32'(bus.dbg_req_ready), 0);
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_fetch_rsp", {bus.fetch_rsp_valid, bus.fetch_rsp_err, bus.fetch_rsp_data[29:0]}, 0);
      chk("rst_dbg_rsp", {bus.dbg_rsp_valid, bus.dbg_rsp_err, bus.dbg_rsp_rdata[29:0]}, 0);
    end else begin
      exp_fv = 0; exp_fe = 0; exp_fd = 0;
      exp_dv = 0; exp_de = 0; exp_dd = 0;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (r.is_fetch) begin
          exp_fv = !r.kill && !bus.fetch_flush;
          exp_fe = r.err;
          exp_fd = r.data;
        end else begin
          exp_dv = 1;
          exp_de = r.err;
          exp_dd = r.data;
        end
      end
      chk("fetch_rsp_valid", 32'(bus.fetch_rsp_valid), 32'(exp_fv));
      if (exp_fv) begin
        chk("fetch_rsp_err", 32'(bus.fetch_rsp_err), 32'(exp_fe));
        chk("fetch_rsp_data", bus.fetch_rsp_data, exp_fd);
      end
      chk("dbg_rsp_valid", 32'(bus.dbg_rsp_valid), 32'(exp_dv));
      if (exp_dv) begin
        chk("dbg_rsp_err", 32'(bus.dbg_rsp_err), 32'(exp_de));
        chk("dbg_rsp_rdata", bus.dbg_rsp_rdata, exp_dd);
      end

      // Debug wins when halted, when alone, or on a tie after a fetch grant.
      gd = bus.dbg_req_valid && (bus.dbg_halt || !bus.fetch_req_valid || !m_last_dbg);
      gf = bus.fetch_req_valid && !bus.dbg_halt && !gd;
      ferr = bad(bus.fetch_addr);
      derr = bad(bus.dbg_addr);
      exp_en = (gd && !derr) || (gf && !ferr);
      exp_we = gd && !derr && bus.dbg_we;
      idx = gd ? word_of(bus.dbg_addr) : word_of(bus.fetch_addr);

      chk("fetch_req_ready", 32'(bus.fetch_req_ready), 32'(gf));
      chk("dbg_req_ready", 32'(bus.dbg_req_ready), 32'(gd));
      chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_en) chk("mem_index", 32'(bus.mem_index), idx);
      if (exp_we) chk("mem_wdata", bus.mem_wdata, bus.dbg_wdata);

      if (gd) begin
        r.is_fetch = 0;
        r.err = derr;
        r.kill = 0;
        r.data = (derr || bus.dbg_we) ? 32'h0 : model_mem[idx];
        exp_q.push_back(r);
        if (exp_we) model_mem[idx] = bus.dbg_wdata;
        m_last_dbg = 1'b1;
      end else if (gf) begin
        r.is_fetch = 1;
        r.err = ferr;
        r.kill = bus.fetch_flush;
        r.data = ferr ? 32'h0 : model_mem[idx];
        exp_q.push_back(r);
        m_last_dbg = 1'b0;
      end
      f_hold = bus.fetch_req_valid && !gf;
      d_hold = bus.dbg_req_valid && !gd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.fetch_req_valid = 0;
    bus.dbg_req_valid = 0;
    bus.dbg_we = 0;
    bus.fetch_flush = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + 32'(4 * (DEPTH - 1));
      1:       return BASE + 32'(4 * DEPTH);
      2:       return BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
      3:       return 32'h0;
      4:       return $urandom();
      default: return BASE + 32'(4 * $urandom_range(0, 63));
    endcase
  endfunction

  logic [31:0] err_addrs [3];

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      dev_mem[i] = minit(i);
      model_mem[i] = minit(i);
    end
    idle();
    bus.dbg_halt = 0;
    bus.fetch_addr = 32'h4;
    bus.dbg_addr = 32'h20;
    bus.dbg_wdata = 0;

    // Requests pending during reset must not be accepted.
    bus.fetch_req_valid = 1;
    bus.dbg_req_valid = 1;
    smp();
    chk("lit_rst_ready", {31'b0, bus.fetch_req_ready | bus.dbg_req_ready}, 0);
    chk("lit_rst_mem_en", 32'(bus.mem_en), 0);
    next();
    idle();
    next();
    rst = 0;

    // Back-to-back fetches map to consecutive word indices.
    bus.fetch_req_valid = 1;
    bus.fetch_addr = 32'h4;
    smp();
    chk("lit_idx0", 32'(bus.mem_index), 0);
    next();
    bus.fetch_addr = 32'h8;
    smp();
    chk("lit_idx1", 32'(bus.mem_index), 1);
    chk("lit_rsp0", bus.fetch_rsp_data, minit(0));
    next();
    bus.fetch_addr = 32'hC;
    smp();
    chk("lit_idx2", 32'(bus.mem_index), 2);
    next();
    idle();
    smp();
    chk("lit_rsp2", bus.fetch_rsp_data, minit(2));

    // Fresh reset, then a persistent tie: debug first, then alternate.
    next();
    rst = 1;
    next();
    rst = 0;
    bus.fetch_req_valid = 1;
    bus.fetch_addr = 32'h10;
    bus.dbg_req_valid = 1;
    bus.dbg_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("lit_rr_dbg", 32'(bus.dbg_req_ready), 32'(k % 2 == 0));
      chk("lit_rr_fetch", 32'(bus.fetch_req_ready), 32'(k % 2 == 1));
      if (k > 0) chk("lit_rr_rsp_port", 32'(bus.dbg_rsp_valid), 32'(k % 2 == 1));
      next();
    end
    idle();

    // Halted: debug owns the port; write then read back.
    bus.dbg_halt = 1;
    bus.fetch_req_valid = 1;
    bus.fetch_addr = 32'h4;
    bus.dbg_req_valid = 1;
    bus.dbg_we = 1;
    bus.dbg_addr = 32'h8;
    bus.dbg_wdata = 32'hDEAD_BEEF;
    smp();
    chk("lit_halt_fready", 32'(bus.fetch_req_ready), 0);
    chk("lit_halt_we", 32'(bus.mem_we), 1);
    next();
    bus.dbg_we = 0;
    smp();
    chk("lit_wr_ack", {bus.dbg_rsp_valid, bus.dbg_rsp_rdata[30:0]}, 32'h8000_0000);
    next();
    bus.dbg_req_valid = 0;
    smp();
    chk("lit_readback", bus.dbg_rsp_rdata, 32'hDEAD_BEEF);
    chk("lit_halt_fready2", 32'(bus.fetch_req_ready), 0);
    next();
    bus.dbg_halt = 0;
    smp();
    chk("lit_unhalt_fready", 32'(bus.fetch_req_ready), 1);
    next();
    idle();

    // Misaligned, below BASE and past the end: accepted, no memory access, error response.
    err_addrs[0] = 32'h6;
    err_addrs[1] = 32'h0;
    err_addrs[2] = BASE + 32'(4 * DEPTH);
    for (int k = 0; k < 4; k++) begin
      bus.fetch_req_valid = (k < 3);
      if (k < 3) bus.fetch_addr = err_addrs[k];
      smp();
      if (k < 3) chk("lit_err_mem_en", 32'(bus.mem_en), 0);
      if (k > 0) chk("lit_err_rsp", {bus.fetch_rsp_err, bus.fetch_rsp_data[30:0]}, 32'h8000_0000);
      next();
    end
    idle();

    // Flush in the response cycle kills only that fetch.
    bus.fetch_req_valid = 1;
    bus.fetch_addr = 32'h4;
    next();
    bus.fetch_req_valid = 0;
    bus.fetch_flush = 1;
    smp();
    chk("lit_flush_kill", 32'(bus.fetch_rsp_valid), 0);
    next();
    bus.fetch_flush = 0;
    bus.fetch_req_valid = 1;
    bus.fetch_addr = 32'h8;
    next();
    idle();
    smp();
    chk("lit_flush_after", {bus.fetch_rsp_valid, bus.fetch_rsp_data[30:0]},
        {1'b1, 31'h5EAD_BEEF});

    // Reset while a debug read is in flight discards its response.
    next();
    bus.dbg_req_valid = 1;
    bus.dbg_addr = 32'h20;
    next();
    idle();
    rst = 1;
    smp();
    chk("lit_rst_drop", 32'(bus.dbg_rsp_valid), 0);
    next();
    rst = 0;
    smp();
    chk("lit_post_rst", {29'b0, bus.dbg_rsp_valid, bus.fetch_rsp_valid, bus.mem_en}, 0);
    next();

    // Randomized traffic; denied requesters hold their request stable.
    for (int c = 0; c < 4000; c++) begin
      if (!f_hold) begin
        bus.fetch_req_valid = ($urandom_range(0, 3) != 0);
        bus.fetch_addr = rand_addr();
      end
      if (!d_hold) begin
        bus.dbg_req_valid = ($urandom_range(0, 2) == 0);
        bus.dbg_we = $urandom_range(0, 1) == 1;
        bus.dbg_addr = rand_addr();
        bus.dbg_wdata = $urandom();
      end
      bus.fetch_flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.dbg_halt = ~bus.dbg_halt;
      rst = ($urandom_range(0, 149) == 0);
      next();
    end
    rst = 0;
    idle();
    bus.dbg_halt = 0;
    next();
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
